systolic_feeder: RTL and testbench

Edge feeder for the N×N PE systolic array: the transmitting side of the PE `a_in`/`b_in`/`we` interface. It accepts matrix A column-by-column and matrix B row-by-row over a valid/ready stream. It then drives the array's left edge (A rows) and top edge (B columns) with the diagonal skew the array requires, raising `we` for exactly the cycles needed to complete one N×N×N multiply-accumulate pass.

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/systolic_skew_lane.sv | 25 ++
 rtl/systolic_feeder.sv | 154 +++++++++++++++
 tb/tb_systolic_feeder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants, state encoding and width helpers for the TPU edge feeder.
package tpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 32;
    localparam int ARRAY_N    = 4;

    localparam int RUN_CNT_W  = $clog2(3 * ARRAY_N - 2);
    localparam int BEAT_CNT_W = $clog2(ARRAY_N);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_t;

    // Counter widths for arbitrary array sizes; a single-bit floor keeps N=2 legal.
    function automatic int run_cnt_width(input int n);
        return (3 * n - 2 > 2) ? $clog2(3 * n - 2) : 1;
    endfunction

    function automatic int beat_cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed edge lane: picks buffer element (t - LANE) while it lies inside the row, else 0.
module systolic_skew_lane
    import tpu_pkg::*;
#(
    parameter int LANE       = 0,
    parameter int N          = ARRAY_N,
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int RUN_W      = RUN_CNT_W
) (
    input  logic [RUN_W-1:0]        i_run_cnt,
    input  logic [N*DATA_WIDTH-1:0] i_row,
    output logic [DATA_WIDTH-1:0]   o_elem
);

    // Matching t against k+LANE avoids a signed subtraction and gives literal-zero padding.
    always_comb begin
        o_elem = '0;
        for (int k = 0; k < N; k++) begin
            if (i_run_cnt == RUN_W'(k + LANE)) begin
                o_elem = i_row[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Edge feeder for the NxN systolic array: buffers A columns / B rows, then drives skewed edges with we.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int N          = ARRAY_N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a_vec,
    input  logic [N*DATA_WIDTH-1:0] in_b_vec,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N*DATA_WIDTH-1:0] b_edge,
    output logic                    we,
    output logic                    busy,
    output logic                    done
);

    localparam int RUN_W  = run_cnt_width(N);
    localparam int BEAT_W = beat_cnt_width(N);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(3 * N - 3);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N - 1);

    feeder_state_t           r_state;
    feeder_state_t           w_state_next;
    logic [BEAT_W-1:0]       r_beat;
    logic [BEAT_W-1:0]       w_beat_next;
    logic [RUN_W-1:0]        r_run;
    logic [RUN_W-1:0]        w_run_next;
    logic                    w_accept;

    // r_a_buf[i] holds row i of A; r_b_buf[j] holds column j of B. Both are indexed by beat.
    logic [N*DATA_WIDTH-1:0] r_a_buf [N];
    logic [N*DATA_WIDTH-1:0] r_b_buf [N];
    logic [N*DATA_WIDTH-1:0] w_a_sel;
    logic [N*DATA_WIDTH-1:0] w_b_sel;

    logic [N*DATA_WIDTH-1:0] r_a_edge;
    logic [N*DATA_WIDTH-1:0] r_b_edge;
    logic                    r_we;
    logic                    r_busy;
    logic                    r_done;

    assign in_ready = rst_n && (r_state == ST_LOAD);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_run_next   = r_run;
        case (r_state)
            ST_LOAD: begin
                if (w_accept) begin
                    if (r_beat == BEAT_LAST) begin
                        w_state_next = ST_RUN;
                        w_beat_next  = '0;
                        w_run_next   = '0;
                    end else begin
                        w_beat_next = r_beat + BEAT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (r_run == RUN_LAST) begin
                    w_state_next = ST_DONE;
                    w_run_next   = '0;
                end else begin
                    w_run_next = r_run + RUN_W'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_LOAD;
                w_beat_next  = '0;
            end
            default: begin
                w_state_next = ST_LOAD;
                w_beat_next  = '0;
                w_run_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_beat  <= '0;
            r_run   <= '0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
            r_run   <= w_run_next;
        end
    end

    // Buffers are deliberately not reset; the beat counter decides what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_a_buf[i][int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] <= in_a_vec[i*DATA_WIDTH +: DATA_WIDTH];
                r_b_buf[i][int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] <= in_b_vec[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        systolic_skew_lane #(
            .LANE       (g),
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .RUN_W      (RUN_W)
        ) u_a_lane (
            .i_run_cnt (w_run_next),
            .i_row     (r_a_buf[g]),
            .o_elem    (w_a_sel[g*DATA_WIDTH +: DATA_WIDTH])
        );

        systolic_skew_lane #(
            .LANE       (g),
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .RUN_W      (RUN_W)
        ) u_b_lane (
            .i_run_cnt (w_run_next),
            .i_row     (r_b_buf[g]),
            .o_elem    (w_b_sel[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Outputs are registered from next-state values so they line up with the RUN cycle they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a_edge <= '0;
            r_b_edge <= '0;
        end else begin
            r_we     <= (w_state_next == ST_RUN);
            r_busy   <= (w_state_next == ST_RUN) || (w_state_next == ST_DONE);
            r_done   <= (w_state_next == ST_DONE);
            r_a_edge <= (w_state_next == ST_RUN) ? w_a_sel : '0;
            r_b_edge <= (w_state_next == ST_RUN) ? w_b_sel : '0;
        end
    end

    assign a_edge = r_a_edge;
    assign b_edge = r_b_edge;
    assign we     = r_we;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: matrix-level edge model plus a behavioural NxN PE array.
module tb_systolic_feeder;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int TLAST = 3 * N - 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] in_a_vec = '0;
    logic [N*DW-1:0] in_b_vec = '0;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;
    logic            we;
    logic            busy;
    logic            done;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0]   mA [N][N];
    logic [DW-1:0]   mB [N][N];
    logic [N*DW-1:0] seenA [TLAST+1];
    logic [N*DW-1:0] seenB [TLAST+1];

    // Behavioural PE array: a flows right, b flows down, MAC when we is high.
    int            acc [N][N];
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic [DW-1:0] aIn [N][N];
    logic [DW-1:0] bIn [N][N];
    int            refC [N][N];

    systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_vec (in_a_vec),
        .in_b_vec (in_b_vec),
        .a_edge   (a_edge),
        .b_edge   (b_edge),
        .we       (we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= 0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (j == 0) aIn[i][j] = a_edge[i*DW +: DW];
                    else        aIn[i][j] = pa[i][j-1];
                    if (i == 0) bIn[i][j] = b_edge[j*DW +: DW];
                    else        bIn[i][j] = pb[i-1][j];
                    if (we) acc[i][j] <= acc[i][j] + int'(aIn[i][j]) * int'(bIn[i][j]);
                    pa[i][j] <= aIn[i][j];
                    pb[i][j] <= bIn[i][j];
                end
            end
        end
    end

    function automatic logic [N*DW-1:0] expA(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = mA[i][t-i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] expB(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mB[t-j][j];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk();
        for (int i = 0; i < N; i++) begin
            in_a_vec[i*DW +: DW] = DW'($urandom);
            in_b_vec[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic randomize_mats();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                mA[i][k] = DW'($urandom);
                mB[i][k] = DW'($urandom);
            end
    endtask

    task automatic accumulate_ref();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++)
                    refC[i][j] += int'(mA[i][k]) * int'(mB[k][j]);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) refC[i][j] = 0;
    endtask

    // Feeds N beats; gapBits bit c gives in_valid for load cycle c (beyond gapLen, valid is held high).
    task automatic load_pass(input bit useGaps, input logic [31:0] gapBits, input int gapLen);
        int k;
        int cyc;
        bit v;
        k = 0;
        cyc = 0;
        while (k < N && cyc < 64) begin
            v = useGaps ? ((cyc < gapLen) ? gapBits[cyc] : 1'b1) : 1'b1;
            in_valid = v;
            if (v) begin
                for (int i = 0; i < N; i++) begin
                    in_a_vec[i*DW +: DW] = mA[i][k];
                    in_b_vec[i*DW +: DW] = mB[k][i];
                end
            end else begin
                drive_junk();
            end
            checks++;
            if ({in_ready, busy, we, done} !== 4'b1000) begin
                failures++;
                $display("[TB] FAIL load_ctl beat=%0d: got ready/busy/we/done=%b expected 1000", k, {in_ready, busy, we, done});
            end
            step();
            cyc++;
            if (v) k++;
        end
        in_valid = 1'b0;
        checks++;
        if (k != N) begin
            failures++;
            $display("[TB] FAIL load_timeout: got %0d beats expected %0d", k, N);
        end
    endtask

    // Walks the RUN and DONE cycles checking edges against the matrix-level skew rule.
    task automatic check_run(input bit junk);
        for (int t = 0; t <= TLAST; t++) begin
            if (junk) begin
                in_valid = 1'b1;
                drive_junk();
            end
            seenA[t] = a_edge;
            seenB[t] = b_edge;
            checks++;
            if ({we, busy, done, in_ready} !== 4'b1100) begin
                failures++;
                $display("[TB] FAIL run_ctl t=%0d: got we/busy/done/ready=%b expected 1100", t, {we, busy, done, in_ready});
            end
            checks++;
            if (a_edge !== expA(t)) begin
                failures++;
                $display("[TB] FAIL a_edge t=%0d: got %h expected %h", t, a_edge, expA(t));
            end
            checks++;
            if (b_edge !== expB(t)) begin
                failures++;
                $display("[TB] FAIL b_edge t=%0d: got %h expected %h", t, b_edge, expB(t));
            end
            step();
        end
        if (junk) drive_junk();
        checks++;
        if ({we, busy, done, in_ready} !== 4'b0110 || a_edge !== '0 || b_edge !== '0) begin
            failures++;
            $display("[TB] FAIL done_cycle: got we/busy/done/ready=%b a=%h b=%h expected 0110 with zero edges",
                     {we, busy, done, in_ready}, a_edge, b_edge);
        end
        step();
        if (!junk) in_valid = 1'b0;
        checks++;
        if ({we, busy, done, in_ready} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL back_to_load: got we/busy/done/ready=%b expected 0001", {we, busy, done, in_ready});
        end
    endtask

    task automatic check_acc(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (acc[i][j] !== refC[i][j]) begin
                    failures++;
                    $display("[TB] FAIL %s PE(%0d,%0d): got %0d expected %0d", tag, i, j, acc[i][j], refC[i][j]);
                end
            end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({in_ready, we, busy, done} !== 4'b0000 || a_edge !== '0 || b_edge !== '0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cyc=%0d: got ready/we/busy/done=%b a=%h b=%h expected all 0",
                         c, {in_ready, we, busy, done}, a_edge, b_edge);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_release: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({busy, we, done} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL idle_no_load cyc=%0d: got busy/we/done=%b expected 000", c, {busy, we, done});
            end
        end
    endtask

    task automatic test_skew();
        $display("[TB] test_skew");
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                mA[i][k] = DW'(4 * i + k + 1);
                mB[i][k] = DW'(16 + 4 * i + k);
            end
        load_pass(1'b0, 32'd0, 0);
        check_run(1'b0);
        checks++;
        if (seenA[0] !== {8'd0, 8'd0, 8'd0, 8'd1}) begin
            failures++;
            $display("[TB] FAIL skew_a_t0: got %h expected 00000001", seenA[0]);
        end
        checks++;
        if (seenA[3][31:24] !== 8'd13) begin
            failures++;
            $display("[TB] FAIL skew_a_t3_lane3: got %0d expected 13", seenA[3][31:24]);
        end
        checks++;
        if (seenA[6] !== {8'd16, 8'd0, 8'd0, 8'd0}) begin
            failures++;
            $display("[TB] FAIL skew_a_t6: got %h expected 10000000", seenA[6]);
        end
        checks++;
        if (seenB[0] !== {8'd0, 8'd0, 8'd0, 8'd16} || seenB[6] !== {8'd31, 8'd0, 8'd0, 8'd0}) begin
            failures++;
            $display("[TB] FAIL skew_b: got t0=%h t6=%h expected 00000010 and 1f000000", seenB[0], seenB[6]);
        end
        checks++;
        if (seenA[9] !== '0 || seenB[9] !== '0) begin
            failures++;
            $display("[TB] FAIL skew_t9_tail: got a=%h b=%h expected 0", seenA[9], seenB[9]);
        end
    endtask

    task automatic test_gapped_load();
        $display("[TB] test_gapped_load");
        randomize_mats();
        load_pass(1'b1, 32'b1011001, 7);
        check_run(1'b0);
    endtask

    task automatic test_input_during_run();
        $display("[TB] test_input_during_run");
        randomize_mats();
        load_pass(1'b0, 32'd0, 0);
        check_run(1'b1);
        randomize_mats();
        load_pass(1'b0, 32'd0, 0);
        check_run(1'b0);
    endtask

    task automatic test_reset_mid_run();
        $display("[TB] test_reset_mid_run");
        randomize_mats();
        load_pass(1'b0, 32'd0, 0);
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (a_edge !== expA(t) || b_edge !== expB(t) || we !== 1'b1) begin
                failures++;
                $display("[TB] FAIL pre_reset_run t=%0d: got a=%h b=%h we=%b expected a=%h b=%h we=1",
                         t, a_edge, b_edge, we, expA(t), expB(t));
            end
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({we, busy, done, in_ready} !== 4'b0000 || a_edge !== '0 || b_edge !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset_drop: got we/busy/done/ready=%b a=%h b=%h expected all 0",
                     {we, busy, done, in_ready}, a_edge, b_edge);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({done, we} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL no_done_in_reset cyc=%0d: got done/we=%b expected 00", c, {done, we});
            end
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) refC[i][j] = 0;
        randomize_mats();
        load_pass(1'b0, 32'd0, 0);
        check_run(1'b0);
        accumulate_ref();
        check_acc("fresh_after_reset");
    endtask

    task automatic test_end_to_end();
        $display("[TB] test_end_to_end");
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                mA[i][k] = DW'(4 * i + k + 1);
                mB[i][k] = (i == k) ? DW'(1) : DW'(0);
            end
        for (int pass = 1; pass <= 2; pass++) begin
            load_pass(1'b0, 32'd0, 0);
            check_run(1'b0);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (acc[i][j] !== pass * (4 * i + j + 1)) begin
                        failures++;
                        $display("[TB] FAIL e2e_pass%0d PE(%0d,%0d): got %0d expected %0d",
                                 pass, i, j, acc[i][j], pass * (4 * i + j + 1));
                    end
                end
        end
        checks++;
        if (acc[2][3] !== 24) begin
            failures++;
            $display("[TB] FAIL e2e_pe23: got %0d expected 24", acc[2][3]);
        end
    endtask

    task automatic test_random_passes();
        $display("[TB] test_random_passes");
        do_reset();
        for (int p = 0; p < 4; p++) begin
            randomize_mats();
            load_pass(1'b1, $urandom, 10);
            check_run(1'($urandom_range(1)));
            accumulate_ref();
            check_acc("random_acc");
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_gapped_load();
        test_input_during_run();
        test_reset_mid_run();
        test_end_to_end();
        test_random_passes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
